nonce_dispatch_scheduler: RTL and testbench

Hands out nonce values to NUM_CORES parallel mining cores (BRAM-fed SHA-256 plus a difficulty check) over a req/gnt handshake, and collects hit reports.
- Round-robin arbitration of nonce requests; fixed-priority arbitration of hit reports.
- Stops on the first hit or when the programmed nonce range is exhausted.
- Sits between the host/control logic and the array of per-core mining FSMs.

---
 rtl/nonce_dispatch_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_nonce_dispatch_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatch_scheduler.sv
// Nonce dispatcher: round-robin grants of a nonce range to NUM_CORES mining cores, first-hit capture.
// Optional NONCE_DISPATCH_STATS_EN adds a saturating 32-bit attempts counter output.
module nonce_dispatch_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2,
    parameter int NONCE_W   = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NONCE_W-1:0]           nonce_base,
    input  logic [NONCE_W-1:0]           nonce_limit,
    input  logic [NUM_CORES-1:0]         core_req,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NUM_CORES*NONCE_W-1:0] core_found_nonce,
    output logic [NUM_CORES-1:0]         core_gnt,
    output logic [NONCE_W-1:0]           grant_nonce,
    output logic [NUM_CORES-1:0]         found_ack,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [NONCE_W-1:0]           nonce_out,
    output logic [IDX_W-1:0]             found_core,
    output logic [2:0]                   state
`ifdef NONCE_DISPATCH_STATS_EN
    ,
    output logic [31:0]                  attempts
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUN       = 3'd1;
    localparam logic [2:0] S_DRAIN     = 3'd2;
    localparam logic [2:0] S_FOUND     = 3'd3;
    localparam logic [2:0] S_EXHAUSTED = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [NONCE_W-1:0]   r_next_nonce;
    logic [NONCE_W-1:0]   r_limit;
    logic [NUM_CORES-1:0] r_outstanding;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_spent;

    logic [NUM_CORES-1:0] r_core_gnt;
    logic [NONCE_W-1:0]   r_grant_nonce;
    logic [NUM_CORES-1:0] r_found_ack;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_found;
    logic [NONCE_W-1:0]   r_nonce_out;
    logic [IDX_W-1:0]     r_found_core;

    logic [NUM_CORES-1:0] w_eligible;
    logic                 w_gnt_any;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [NUM_CORES-1:0] w_gnt_vec;
    logic                 w_gnt_last;
    logic                 w_gnt_fire;
    logic                 w_hit_any;
    logic [IDX_W-1:0]     w_hit_idx;
    logic [NUM_CORES-1:0] w_hit_vec;
    logic                 w_hit_fire;
    logic                 w_start_ok;
    logic                 w_idle_like;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_found_nxt;
    logic [NONCE_W-1:0]   w_found_nonce [NUM_CORES];

    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        f_wrap = IDX_W'(v % NUM_CORES);
    endfunction

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign w_found_nonce[g] = core_found_nonce[g*NONCE_W +: NONCE_W];
    end

    assign w_eligible  = core_req & ~r_outstanding;
    assign w_gnt_vec   = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_hit_vec   = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_hit_idx;
    assign w_hit_any   = |core_found;
    // Last grant of the range: either the programmed limit or the top of the nonce space.
    assign w_gnt_last  = (r_next_nonce == r_limit) || (r_next_nonce == {NONCE_W{1'b1}});
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_FOUND) || (r_state == S_EXHAUSTED);

    // Round-robin search beginning one past the last granted core.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!w_gnt_any && w_eligible[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    always_comb begin
        w_hit_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (core_found[f_wrap(k)]) begin
                w_hit_idx = f_wrap(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (start) begin
                        w_state_nxt = (nonce_base > nonce_limit) ? S_EXHAUSTED : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_hit_any) begin
                        w_state_nxt = S_FOUND;
                    end else if (w_gnt_any && !r_spent && w_gnt_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_hit_any) begin
                        w_state_nxt = S_FOUND;
                    end else if (r_outstanding == '0) begin
                        w_state_nxt = S_EXHAUSTED;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A hit in the same cycle suppresses any grant; abort suppresses both.
    always_comb begin
        w_start_ok  = start && !abort && w_idle_like;
        w_hit_fire  = !abort && w_hit_any && ((r_state == S_RUN) || (r_state == S_DRAIN));
        w_gnt_fire  = !abort && (r_state == S_RUN) && !w_hit_any && !r_spent && w_gnt_any;
        w_busy_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
        w_done_nxt  = (w_state_nxt == S_FOUND) || (w_state_nxt == S_EXHAUSTED);
        w_found_nxt = (w_state_nxt == S_FOUND);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_next_nonce  <= '0;
            r_limit       <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_spent       <= 1'b0;
            r_core_gnt    <= '0;
            r_grant_nonce <= '0;
            r_found_ack   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_nonce_out   <= '0;
            r_found_core  <= '0;
        end else begin
            r_core_gnt  <= w_gnt_fire ? w_gnt_vec : '0;
            r_found_ack <= w_hit_fire ? w_hit_vec : '0;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_found     <= w_found_nxt;

            if (w_gnt_fire) begin
                r_grant_nonce <= r_next_nonce;
                r_rr_ptr      <= f_wrap(int'(w_gnt_idx) + 1);
            end

            if (w_hit_fire) begin
                r_nonce_out  <= w_found_nonce[w_hit_idx];
                r_found_core <= w_hit_idx;
            end

            if (abort || w_start_ok || w_hit_fire) begin
                r_outstanding <= '0;
            end else begin
                r_outstanding <= (r_outstanding & ~core_done) | (w_gnt_fire ? w_gnt_vec : '0);
            end

            if (w_start_ok) begin
                r_next_nonce <= nonce_base;
                r_limit      <= nonce_limit;
                r_spent      <= 1'b0;
            end else if (abort) begin
                r_spent <= 1'b0;
            end else if (w_gnt_fire) begin
                if (w_gnt_last) begin
                    r_spent <= 1'b1;
                end
                // Hold at the top of the nonce space rather than wrapping to zero.
                if (r_next_nonce != {NONCE_W{1'b1}}) begin
                    r_next_nonce <= r_next_nonce + 1'b1;
                end
            end
        end
    end

`ifdef NONCE_DISPATCH_STATS_EN
    logic [31:0] r_attempts;
    logic [32:0] w_attempt_inc;
    logic [32:0] w_attempt_sum;

    assign w_attempt_inc = 33'($countones(core_done & r_outstanding)) + {32'd0, w_hit_fire};
    assign w_attempt_sum = {1'b0, r_attempts} + w_attempt_inc;

    always_ff @(posedge clock) begin
        if (!reset || w_start_ok) begin
            r_attempts <= '0;
        end else if (w_attempt_sum[32]) begin
            r_attempts <= 32'hFFFF_FFFF;
        end else begin
            r_attempts <= w_attempt_sum[31:0];
        end
    end

    assign attempts = r_attempts;
`endif

    assign core_gnt    = r_core_gnt;
    assign grant_nonce = r_grant_nonce;
    assign found_ack   = r_found_ack;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign nonce_out   = r_nonce_out;
    assign found_core  = r_found_core;
    assign state       = r_state;

endmodule

// File: tb/tb_nonce_dispatch_scheduler.sv
// Scoreboard bench for nonce_dispatch_scheduler: behavioural cores, expected-grant queue, directed hit/abort cases.
module tb_nonce_dispatch_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [31:0]  nonce_base;
    logic [31:0]  nonce_limit;
    logic [3:0]   core_req;
    logic [3:0]   core_done;
    logic [3:0]   core_found;
    logic [127:0] core_found_nonce;
    logic [3:0]   core_gnt;
    logic [31:0]  grant_nonce;
    logic [3:0]   found_ack;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  nonce_out;
    logic [1:0]   found_core;
    logic [2:0]   state;
`ifdef NONCE_DISPATCH_STATS_EN
    logic [31:0]  attempts;
`endif

    typedef struct packed {
        logic [3:0]  gnt;
        logic [31:0] nonce;
    } gnt_t;

    gnt_t       exp_q[$];
    logic [3:0] en;
    int         cnt[4];
    int         n_checks = 0;
    int         n_errors = 0;

    nonce_dispatch_scheduler #(.NUM_CORES(4), .IDX_W(2), .NONCE_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .nonce_base       (nonce_base),
        .nonce_limit      (nonce_limit),
        .core_req         (core_req),
        .core_done        (core_done),
        .core_found       (core_found),
        .core_found_nonce (core_found_nonce),
        .core_gnt         (core_gnt),
        .grant_nonce      (grant_nonce),
        .found_ack        (found_ack),
        .busy             (busy),
        .done             (done),
        .found            (found),
        .nonce_out        (nonce_out),
        .found_core       (found_core),
        .state            (state)
`ifdef NONCE_DISPATCH_STATS_EN
        ,
        .attempts         (attempts)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic [3:0] g, input logic [31:0] n);
        gnt_t e;
        e.gnt   = g;
        e.nonce = n;
        exp_q.push_back(e);
    endfunction

    // One clock: sample just after the edge, score grants, advance the core models, drop pulses.
    task automatic step();
        gnt_t e;
        @(posedge clock);
        #1;
        if (core_gnt !== 4'b0) begin
            if (exp_q.size() == 0) begin
                check_eq("gnt_unexpected", 64'(core_gnt), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("gnt_core", 64'(core_gnt), 64'(e.gnt));
                check_eq("gnt_nonce", 64'(grant_nonce), 64'(e.nonce));
            end
        end
        core_done = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) core_done[i] = 1'b1;
            end
            if (core_gnt[i] === 1'b1) cnt[i] = 3;
            core_req[i] = en[i] && (cnt[i] == 0);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] l);
        nonce_base  = b;
        nonce_limit = l;
        start       = 1'b1;
        step();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int n = 0; n < budget && state !== s; n++) step();
        check_eq(tag, 64'(state), 64'(s));
    endtask

    task automatic wait_ack(input int budget);
        for (int n = 0; n < budget && found_ack === 4'b0; n++) step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        nonce_base = '0; nonce_limit = '0;
        core_req = '0; core_done = '0; core_found = '0; core_found_nonce = '0;
        en = 4'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;

        repeat (3) step();
        check_eq("rst_gnt", 64'(core_gnt), 64'd0);
        check_eq("rst_gnonce", 64'(grant_nonce), 64'd0);
        check_eq("rst_ack", 64'(found_ack), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_found", 64'(found), 64'd0);
        check_eq("rst_nonce_out", 64'(nonce_out), 64'd0);
        check_eq("rst_found_core", 64'(found_core), 64'd0);
        check_eq("rst_state", 64'(state), 64'd0);
        reset = 1'b1;

        // Range 0x10..0x13 over four cores in order.
        en = 4'b1111;
        step();
        for (int k = 0; k < 4; k++) push_exp(4'(4'b0001 << k), 32'h10 + 32'(k));
        do_start(32'h10, 32'h13);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_state(3'd4, 40, "t1_state_exh");
        check_eq("t1_done", 64'(done), 64'd1);
        check_eq("t1_found", 64'(found), 64'd0);
        check_eq("t1_busy_low", 64'(busy), 64'd0);
        check_eq("t1_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef NONCE_DISPATCH_STATS_EN
        check_eq("t1_attempts", 64'(attempts), 64'd4);
`endif

        // Core 2 reports a hit mid-range.
        for (int k = 0; k < 12; k++) push_exp(4'(4'b0001 << (k % 4)), 32'h100 + 32'(k));
        do_start(32'h100, 32'h1FF);
        repeat (7) step();
        core_found_nonce[2*32 +: 32] = 32'h105;
        core_found[2] = 1'b1;
        wait_ack(10);
        check_eq("t2_ack", 64'(found_ack), 64'b0100);
        check_eq("t2_gnt_at_hit", 64'(core_gnt), 64'd0);
        core_found[2] = 1'b0;
        exp_q.delete();
        check_eq("t2_state", 64'(state), 64'd3);
        check_eq("t2_nonce_out", 64'(nonce_out), 64'h105);
        check_eq("t2_found_core", 64'(found_core), 64'd2);
        check_eq("t2_found", 64'(found), 64'd1);
        check_eq("t2_done", 64'(done), 64'd1);
        step();
        check_eq("t2_ack_pulse", 64'(found_ack), 64'd0);
        repeat (10) step();
        check_eq("t2_state_hold", 64'(state), 64'd3);

        // Simultaneous hits on cores 1 and 3.
        en = 4'b0000;
        repeat (6) step();
        do_start(32'h200, 32'h2FF);
        step();
        check_eq("t3_state_run", 64'(state), 64'd1);
        core_found_nonce[1*32 +: 32] = 32'h211;
        core_found_nonce[3*32 +: 32] = 32'h233;
        core_found = 4'b1010;
        wait_ack(10);
        check_eq("t3_ack", 64'(found_ack), 64'b0010);
        check_eq("t3_found_core", 64'(found_core), 64'd1);
        check_eq("t3_nonce_out", 64'(nonce_out), 64'h211);
        core_found[1] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("t3_no_ack3", 64'(found_ack), 64'd0);
        end
        core_found = 4'b0;

        // Top of the nonce space: two grants, no wrap.
        en = 4'b0001;
        step();
        push_exp(4'b0001, 32'hFFFF_FFFE);
        push_exp(4'b0001, 32'hFFFF_FFFF);
        do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_state(3'd4, 40, "t4_state_exh");
        check_eq("t4_done", 64'(done), 64'd1);
        check_eq("t4_q_empty", 64'(exp_q.size()), 64'd0);
        repeat (6) step();

        // Abort with three grants outstanding, then restart at base 5.
        en = 4'b0111;
        step();
        push_exp(4'b0010, 32'h40);
        push_exp(4'b0100, 32'h41);
        push_exp(4'b0001, 32'h42);
        do_start(32'h40, 32'h4F);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        check_eq("t5_three_gnts", 64'(exp_q.size()), 64'd0);
        abort = 1'b1;
        step();
        check_eq("t5_state_idle", 64'(state), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_done", 64'(done), 64'd0);
        repeat (6) step();
        check_eq("t5_still_idle", 64'(state), 64'd0);
        push_exp(4'b0010, 32'h5);
        do_start(32'h5, 32'h5);
        wait_state(3'd4, 30, "t5_restart_exh");
        check_eq("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // Empty range goes straight to EXHAUSTED.
        repeat (4) step();
        do_start(32'h9, 32'h3);
        check_eq("t6_state", 64'(state), 64'd4);
        check_eq("t6_done", 64'(done), 64'd1);
        check_eq("t6_busy", 64'(busy), 64'd0);
`ifdef NONCE_DISPATCH_STATS_EN
        check_eq("t6_attempts", 64'(attempts), 64'd0);
`endif
        repeat (5) step();
        check_eq("t6_state_hold", 64'(state), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
